// File: rtl/rtc_pkg.sv
`default_nettype none
// ============================================================================
// Package    : rtc_pkg
// Description: Shared types and default timing constants for the RTC
//              time-set input path (button conditioning).
// Contents   : btn_state_e     - per-button pulse/auto-repeat state
//              TICK_DIV_50M    - 1 ms tick terminal count at 50 MHz
//              DEBOUNCE_MS     - debounce window depth in ticks
//              REPEAT_DELAY_MS - hold time before auto-repeat, in ticks
//              REPEAT_RATE_MS  - auto-repeat interval, in ticks
// Revision   : 1.0 - initial release
// ============================================================================
package rtc_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_DELAY  = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_e;

  localparam int TICK_DIV_50M    = 49999;
  localparam int DEBOUNCE_MS     = 8;
  localparam int REPEAT_DELAY_MS = 500;
  localparam int REPEAT_RATE_MS  = 100;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module     : button_debounce
// Description: One conditioned input: 2-flop synchronizer, tick-sampled
//              debounce window with hysteresis, and (optionally) a press
//              pulse generator with hold-to-auto-repeat.
// Ports      : clock50MHz - system clock
//              resetn     - asynchronous active-low reset
//              tick       - shared 1 ms sample strobe
//              raw_in     - raw asynchronous pin
//              enable     - pulses allowed only while high (manual-set mode)
//              level      - debounced level, active-high
//              pulse      - one-clock increment strobe (0 when REPEAT_EN=0)
// Revision   : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_MS     = rtc_pkg::DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = rtc_pkg::REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = rtc_pkg::REPEAT_RATE_MS,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clock50MHz,
  input  logic resetn,
  input  logic tick,
  input  logic raw_in,
  input  logic enable,
  output logic level,
  output logic pulse
);
  import rtc_pkg::*;

  localparam int c_MS_MAX = max_int(REPEAT_DELAY_MS, REPEAT_RATE_MS);
  localparam int c_MS_W   = $clog2(c_MS_MAX + 1);
  // An active-low pin idles high, so its synchronizer resets to "released".
  localparam logic [1:0] c_SYNC_RST = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [1:0]             r_sync;
  logic                   w_sample;
  logic [DEBOUNCE_MS-1:0] r_shift;
  logic [DEBOUNCE_MS-1:0] w_shift_next;
  logic                   r_level;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      r_sync <= c_SYNC_RST;
    end else begin
      r_sync <= {r_sync[0], raw_in};
    end
  end

  assign w_sample     = ACTIVE_LOW ? ~r_sync[1] : r_sync[1];
  assign w_shift_next = {r_shift[DEBOUNCE_MS-2:0], w_sample};

  // Level is updated from the post-shift window so it changes in the cycle
  // right after the deciding tick; a mixed window keeps the old level.
  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '0;
      r_level <= 1'b0;
    end else if (tick) begin
      r_shift <= w_shift_next;
      if (&w_shift_next) begin
        r_level <= 1'b1;
      end else if (~|w_shift_next) begin
        r_level <= 1'b0;
      end
    end
  end

  assign level = r_level;

  generate
    if (REPEAT_EN) begin : g_repeat
      localparam logic [c_MS_W-1:0] c_DELAY = c_MS_W'(REPEAT_DELAY_MS);
      localparam logic [c_MS_W-1:0] c_RATE  = c_MS_W'(REPEAT_RATE_MS);

      btn_state_e        r_state;
      logic [c_MS_W-1:0] r_ms_cnt;
      logic [c_MS_W-1:0] w_ms_inc;
      logic              r_level_d;
      logic              r_pulse;

      assign w_ms_inc = r_ms_cnt + c_MS_W'(1);

      always_ff @(posedge clock50MHz or negedge resetn) begin
        if (!resetn) begin
          r_state   <= BTN_IDLE;
          r_ms_cnt  <= '0;
          r_level_d <= 1'b0;
          r_pulse   <= 1'b0;
        end else begin
          r_level_d <= r_level;
          r_pulse   <= 1'b0;
          if (!r_level || !enable) begin
            // Release or leaving set mode aborts silently.
            r_state  <= BTN_IDLE;
            r_ms_cnt <= '0;
          end else begin
            case (r_state)
              BTN_IDLE: begin
                // Only a fresh rising edge arms; a level that was already
                // high when set mode came on never fires.
                if (!r_level_d) begin
                  r_pulse  <= 1'b1;
                  r_ms_cnt <= '0;
                  r_state  <= BTN_DELAY;
                end
              end
              BTN_DELAY: begin
                if (tick) begin
                  if (w_ms_inc >= c_DELAY) begin
                    r_pulse  <= 1'b1;
                    r_ms_cnt <= '0;
                    r_state  <= BTN_REPEAT;
                  end else begin
                    r_ms_cnt <= w_ms_inc;
                  end
                end
              end
              BTN_REPEAT: begin
                if (tick) begin
                  if (w_ms_inc >= c_RATE) begin
                    r_pulse  <= 1'b1;
                    r_ms_cnt <= '0;
                  end else begin
                    r_ms_cnt <= w_ms_inc;
                  end
                end
              end
              default: begin
                r_state  <= BTN_IDLE;
                r_ms_cnt <= '0;
              end
            endcase
          end
        end
      end

      assign pulse = r_pulse;
    end else begin : g_level_only
      logic w_unused_enable;
      assign w_unused_enable = enable;
      assign pulse = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module     : button_conditioner
// Description: Front end of the RTC time-set path. Synchronizes and
//              debounces the push buttons and the manual-set switch on a
//              shared 1 ms tick and produces single-cycle increment pulses
//              with hold-to-auto-repeat for the HH:MM:SS counters.
// Ports      : clock50MHz  - 50 MHz system clock
//              resetn      - asynchronous active-low reset
//              push_button - raw buttons, active-low
//              man_switch  - raw manual-set switch, 1 = set mode
//              held        - debounced button levels, active-high
//              man_mode    - debounced man_switch
//              inc_pulse   - one-clock increment strobe per button
//              tick_1khz   - one-clock 1 ms tick, shared downstream
// Revision   : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int N_BUTTONS       = 3,
  parameter int TICK_DIV        = rtc_pkg::TICK_DIV_50M,
  parameter int DEBOUNCE_MS     = rtc_pkg::DEBOUNCE_MS,
  parameter int REPEAT_DELAY_MS = rtc_pkg::REPEAT_DELAY_MS,
  parameter int REPEAT_RATE_MS  = rtc_pkg::REPEAT_RATE_MS
) (
  input  logic                 clock50MHz,
  input  logic                 resetn,
  input  logic [N_BUTTONS-1:0] push_button,
  input  logic                 man_switch,
  output logic [N_BUTTONS-1:0] held,
  output logic                 man_mode,
  output logic [N_BUTTONS-1:0] inc_pulse,
  output logic                 tick_1khz
);
  import rtc_pkg::*;

  localparam int c_TICK_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV);

  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_man_pulse_unused;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == c_TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
    end
  end

  assign tick_1khz = (r_tick_cnt == c_TICK_LAST);

  generate
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_MS     (DEBOUNCE_MS),
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_RATE_MS  (REPEAT_RATE_MS),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_EN       (1'b1)
      ) u_btn (
        .clock50MHz (clock50MHz),
        .resetn     (resetn),
        .tick       (tick_1khz),
        .raw_in     (push_button[gi]),
        .enable     (man_mode),
        .level      (held[gi]),
        .pulse      (inc_pulse[gi])
      );
    end
  endgenerate

  button_debounce #(
    .DEBOUNCE_MS     (DEBOUNCE_MS),
    .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
    .REPEAT_RATE_MS  (REPEAT_RATE_MS),
    .ACTIVE_LOW      (1'b0),
    .REPEAT_EN       (1'b0)
  ) u_man (
    .clock50MHz (clock50MHz),
    .resetn     (resetn),
    .tick       (tick_1khz),
    .raw_in     (man_switch),
    .enable     (1'b0),
    .level      (man_mode),
    .pulse      (w_man_pulse_unused)
  );

endmodule
`default_nettype wire
